// File: rtl/key_pkg.sv
// Shared types and default timing for the key debouncer.
// Defaults assume a 50 MHz clock: 20 ms debounce window, 1 s long-press threshold.
package key_pkg;

    typedef enum logic [1:0] {
        UP      = 2'd0,
        FILT_DN = 2'd1,
        DOWN    = 2'd2,
        FILT_UP = 2'd3
    } key_state_t;

    localparam int CNT_MAX_DEF  = 1000000;
    localparam int LONG_MAX_DEF = 50000000;

endpackage

// File: rtl/key_debounce_if.sv
// Key-event bundle: raw key towards the debouncer, debounced level and events back.
// The master side owns the raw key; the slave side is the debouncer.
interface key_debounce_if;

    logic key_in;
    logic key_value;
    logic key_press;
    logic key_release;
    logic key_long;

    modport master (
        output key_in,
        input  key_value,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  key_in,
        output key_value,
        output key_press,
        output key_release,
        output key_long
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Both flops reset to RESET_VAL so the downstream logic sees a defined idle level.
module sync_2ff #(
    parameter bit RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments keep meta and q as two distinct flops; blocking would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Debounced key with one-cycle press, release and long-press events.
// A level change is accepted only after CNT_MAX consecutive agreeing samples.
module key_debounce
    import key_pkg::*;
#(
    parameter int CNT_MAX  = CNT_MAX_DEF,
    parameter int LONG_MAX = LONG_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    key_debounce_if.slave kif
);

    localparam int CNT_W  = $clog2(CNT_MAX);
    localparam int HOLD_W = $clog2(LONG_MAX);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CNT_MAX - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MAX - 1);

    if (CNT_MAX < 2) begin : g_bad_cnt_max
        $error("key_debounce: CNT_MAX must be at least 2");
    end

    if (LONG_MAX <= CNT_MAX) begin : g_bad_long_max
        $error("key_debounce: LONG_MAX must exceed CNT_MAX");
    end

    key_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [HOLD_W-1:0] hold;
    logic              long_done;
    logic              key_s;

    logic [CNT_W-1:0]  cnt_inc;
    logic              filt_done;
    logic              hold_step;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (kif.key_in),
        .q   (key_s)
    );

    // The entry cycle into a filter state counts as the first qualifying sample,
    // so the level flips on the cycle the incremented count reaches CNT_MAX-1.
    assign cnt_inc   = cnt + 1'b1;
    assign filt_done = (cnt_inc == CNT_LAST);

    // The hold counter runs through DOWN and FILT_UP, except on the cycle a
    // release is confirmed, so a long-press event never coincides with a release.
    assign hold_step = (state == DOWN) ||
                       ((state == FILT_UP) && !(key_s && filt_done));

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= UP;
            cnt             <= '0;
            hold            <= '0;
            long_done       <= 1'b0;
            kif.key_value   <= 1'b1;
            kif.key_press   <= 1'b0;
            kif.key_release <= 1'b0;
            kif.key_long    <= 1'b0;
        end else begin
            // NOTE: event outputs default low every cycle, so any branch that sets one yields a single-cycle pulse.
            kif.key_press   <= 1'b0;
            kif.key_release <= 1'b0;
            kif.key_long    <= 1'b0;

            unique case (state)
                UP: begin
                    if (!key_s) begin
                        state <= FILT_DN;
                        cnt   <= '0;
                    end
                end

                FILT_DN: begin
                    if (key_s) begin
                        state <= UP;
                        cnt   <= '0;
                    end else if (filt_done) begin
                        state         <= DOWN;
                        cnt           <= '0;
                        hold          <= '0;
                        long_done     <= 1'b0;
                        kif.key_value <= 1'b0;
                        kif.key_press <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                DOWN: begin
                    if (key_s) begin
                        state <= FILT_UP;
                        cnt   <= '0;
                    end
                end

                FILT_UP: begin
                    if (!key_s) begin
                        state <= DOWN;
                        cnt   <= '0;
                    end else if (filt_done) begin
                        state           <= UP;
                        cnt             <= '0;
                        kif.key_value   <= 1'b1;
                        kif.key_release <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
            endcase

            // Saturate at LONG_MAX-1; long_done limits the event to one per press.
            if (hold_step) begin
                if (hold == HOLD_LAST) begin
                    if (!long_done) begin
                        kif.key_long <= 1'b1;
                        long_done    <= 1'b1;
                    end
                end else begin
                    hold <= hold + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter CNT_MAX, default 1000000, is the debounce window in clk cycles (20 ms at 50 MHz) and SHALL be at least 2.
REQ-002 Parameter LONG_MAX, default 50000000, is the long-press threshold in clk cycles while confirmed pressed (1 s at 50 MHz) and SHALL be greater than CNT_MAX.
REQ-003 clk  input  1  is the single clock; all logic SHALL be posedge clk.
REQ-004 rst  input  1  is a synchronous, active-high reset sampled on posedge clk.
REQ-005 key_in  input  1  is the raw mechanical key, asynchronous, active-low (pressed = 0), idle 1.
REQ-006 key_value  output  1  is the debounced key level (registered), idle 1.
REQ-007 key_press  output  1  is a one-cycle pulse on each confirmed press (1->0 of key_value); it is the event consumed by the downstream pin-toggle logic.
REQ-008 key_release  output  1  is a one-cycle pulse on each confirmed release (0->1 of key_value).
REQ-009 key_long  output  1  is a one-cycle pulse when a confirmed press has lasted LONG_MAX cycles.

Function
REQ-010 key_in SHALL pass through a two-flop synchronizer (reset value 1); only the synchronized value key_s drives the FSM.
REQ-011 The FSM SHALL have the states UP, FILT_DN, DOWN and FILT_UP; its reset state is UP.
REQ-012 From UP on key_s==0, the FSM SHALL go to FILT_DN with cnt=0; otherwise it stays in UP.
REQ-013 In FILT_DN, key_s==1 SHALL return the FSM to UP with cnt=0 and no output pulse (a bounce is rejected).
REQ-014 In FILT_DN with key_s==0, cnt SHALL increment; when cnt==CNT_MAX-1 the FSM SHALL go to DOWN, key_value<=0 and key_press<=1 for exactly one cycle.
REQ-015 FILT_UP SHALL mirror FILT_DN with polarity inverted: it exits to DOWN on key_s==0, or to UP with key_value<=1 and key_release<=1 for one cycle.
REQ-016 In DOWN, key_s==1 SHALL move the FSM to FILT_UP with cnt=0; the hold counter SHALL keep running during FILT_UP.
REQ-017 The hold counter SHALL clear on entry to DOWN from FILT_DN and increment each cycle in DOWN/FILT_UP; on reaching LONG_MAX-1, key_long<=1 for one cycle, and the counter SHALL saturate so that there is exactly one key_long per press.
REQ-018 Latency: a clean fall of key_in SHALL produce key_press exactly CNT_MAX+2 cycles later (2 synchronizer cycles plus CNT_MAX filter cycles); release latency is identical.
REQ-019 cnt width SHALL be $clog2(CNT_MAX); hold counter width SHALL be $clog2(LONG_MAX); neither counter SHALL wrap.
REQ-020 key_press, key_release and key_long SHALL never be asserted simultaneously, and no pulse SHALL exceed one cycle.
REQ-021 A bounce shorter than CNT_MAX cycles in any state SHALL produce no change of key_value and no pulse.

Reset
REQ-022 When rst==1 at posedge clk: state=UP, cnt=0, hold=0, synchronizer flops=1, key_value=1, key_press=0, key_release=0, key_long=0.
REQ-023 Reset asserted mid-filter or mid-press SHALL discard all progress; after reset, a key still held low SHALL be re-qualified from UP, taking a full CNT_MAX+2 cycles.

Structure
REQ-024 Package key_pkg SHALL hold the state enum (UP, FILT_DN, DOWN, FILT_UP) and the default values of CNT_MAX and LONG_MAX.
REQ-025 The synchronizer SHALL be a separate sub-module sync_2ff (parameter RESET_VAL=1, ports clk, rst, d, q); the rest of the block SHALL be a single FSM and counter module.

Verification (bench uses CNT_MAX=8, LONG_MAX=32)
REQ-026 Reset, then key_in held at 1 for 100 cycles -> key_value=1 throughout, and no pulse is ever asserted.
REQ-027 key_in falls cleanly and is held low 20 cycles -> key_press is high for one cycle exactly 10 cycles after the fall, and key_value=0 from that cycle on.
REQ-028 key_in toggles with low and high periods of 3 cycles for 40 cycles, then settles to 0 -> no pulse during the bounce, and a single key_press 10 cycles after settling.
REQ-029 Key held low 50 cycles after key_press -> exactly one key_long, 32 cycles after key_press; on release, key_release 10 cycles after key_in rises.
REQ-030 Key held low, rst pulsed for 1 cycle at 5 cycles after key_press -> outputs return to reset values, then a fresh key_press arrives 10 cycles after rst deasserts (key_in still 0).
REQ-031 During DOWN, a 4-cycle high glitch on key_in -> no key_release, key_value stays 0, and the hold count continues so that key_long timing is unchanged.
